// File: rtl/nird_interp_pkg.sv
// Shared constants, weight table and radius helpers for the NIRD ring-sampling stage.
package nird_interp_pkg;

   // Fractional bits of the Q(DW).16 ring samples and of the Q0.16 weights.
   localparam int unsigned FRAC = 16;
   // Weights need one extra bit so that wA = 1.0 (65536) is representable.
   localparam int unsigned WW = FRAC + 1;
   localparam int unsigned RADIUS_W = 3;

   // Bilinear weights per radius 1..4; every row obeys wA + 2*wBC + wD = 65536.
   localparam logic [WW-1:0] W_A  [1:4] = '{17'd65536, 17'd22488, 17'd50599, 17'd1929};
   localparam logic [WW-1:0] W_BC [1:4] = '{17'd0,     17'd15902, 17'd6986,  17'd9315};
   localparam logic [WW-1:0] W_D  [1:4] = '{17'd0,     17'd11244, 17'd965,   17'd44977};

   // Radius 0 and anything above the configured maximum are not supported.
   function automatic logic radius_illegal(input logic [RADIUS_W-1:0] r,
                                           input int unsigned r_max);
      return (r == '0) || ({29'b0, r} > r_max);
   endfunction

   // Map a requested radius onto a table row; unsupported radii fall back to r_max.
   function automatic logic [RADIUS_W-1:0] clamp_radius(input logic [RADIUS_W-1:0] r,
                                                        input int unsigned r_max);
      return radius_illegal(r, r_max) ? RADIUS_W'(r_max) : r;
   endfunction

endpackage

// File: rtl/interp_bilinear4.sv
// One diagonal ring sample: A*wA + (B+C)*wBC + D*wD over three stall-able stages.
module interp_bilinear4
   import nird_interp_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic [4*DW-1:0]     corners_i,
   input  logic [WW-1:0]       w_a_i,
   input  logic [WW-1:0]       w_bc_i,
   input  logic [WW-1:0]       w_d_i,
   output logic [DW+FRAC-1:0]  y_o
);

   localparam int unsigned PW = DW + WW;

   logic [DW-1:0]        a, b, c, d;
   logic [DW:0]          bc;
   logic [PW-1:0]        p_a_d, p_bc_d, p_d_d;
   logic [PW-1:0]        p_a_q, p_bc_q, p_d_q;
   logic [PW-1:0]        s_abc_d, s_abc_q, s_d_q;
   logic [DW+FRAC-1:0]   y_d, y_q;

   // Multiply stage: corner sums and weighted products, zero-extended to product width.
   always_comb begin
      {d, c, b, a} = corners_i;
      bc     = {1'b0, b} + {1'b0, c};
      p_a_d  = {{WW{1'b0}}, a} * {{DW{1'b0}}, w_a_i};
      p_bc_d = {{(WW-1){1'b0}}, bc} * {{DW{1'b0}}, w_bc_i};
      p_d_d  = {{WW{1'b0}}, d} * {{DW{1'b0}}, w_d_i};
   end

   // Partial and final sums; the weight identity keeps the result within DW+16 bits.
   always_comb begin
      s_abc_d = p_a_q + p_bc_q;
      y_d     = (DW + FRAC)'(s_abc_q + s_d_q);
   end

   // Pipeline registers P2..P4, all held together while the ring is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_a_q   <= '0;
         p_bc_q  <= '0;
         p_d_q   <= '0;
         s_abc_q <= '0;
         s_d_q   <= '0;
         y_q     <= '0;
      end else if (en_i) begin
         p_a_q   <= p_a_d;
         p_bc_q  <= p_bc_d;
         p_d_q   <= p_d_d;
         s_abc_q <= s_abc_d;
         s_d_q   <= p_d_q;
         y_q     <= y_d;
      end
   end

   assign y_o = y_q;

endmodule

// File: rtl/interpolation_ring.sv
// Ring-sampling stage: 4 delay-matched axial taps and 4 bilinear diagonal taps, valid/ready.
module interpolation_ring
   import nird_interp_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned R_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                data_valid_i,
   output logic                ready_o,
   input  logic                finish_i,
   input  logic [2:0]          radius_i,
   input  logic [DW-1:0]       S_0_i,
   input  logic [DW-1:0]       S_90_i,
   input  logic [DW-1:0]       S_180_i,
   input  logic [DW-1:0]       S_270_i,
   input  logic [4*DW-1:0]     S_45_i,
   input  logic [4*DW-1:0]     S_135_i,
   input  logic [4*DW-1:0]     S_225_i,
   input  logic [4*DW-1:0]     S_315_i,
   output logic [DW+FRAC-1:0]  S1_o,
   output logic [DW+FRAC-1:0]  S2_o,
   output logic [DW+FRAC-1:0]  S3_o,
   output logic [DW+FRAC-1:0]  S4_o,
   output logic [DW+FRAC-1:0]  S5_o,
   output logic [DW+FRAC-1:0]  S6_o,
   output logic [DW+FRAC-1:0]  S7_o,
   output logic [DW+FRAC-1:0]  S8_o,
   output logic                data_valid_o,
   input  logic                ready_i,
   output logic                finish_o,
   output logic                cfg_err_o
);

   logic                        advance;
   logic [3:0]                  v_q;
   logic [3:0]                  fin_q;
   logic [RADIUS_W-1:0]         rad_q;
   // Axial delay line, [stage][lane] with lanes 0/90/180/270 deg.
   logic [3:0][3:0][DW-1:0]     ax_q;
   // P1 corner registers, lanes 45/135/225/315 deg.
   logic [3:0][4*DW-1:0]        dg_q;
   logic [RADIUS_W-1:0]         w_idx;
   logic [WW-1:0]               w_a, w_bc, w_d;
   logic [3:0][DW+FRAC-1:0]     diag_y;
   logic                        cfg_err_q;

   // One global enable: the whole ring moves unless a delivered beat is being refused.
   assign advance = !data_valid_o || ready_i;
   assign ready_o = advance;

   // Weight lookup from the radius latched in P1; unsupported radii use the R_MAX row.
   always_comb begin
      w_idx = clamp_radius(rad_q, R_MAX);
      w_a   = W_A[4];
      w_bc  = W_BC[4];
      w_d   = W_D[4];
      case (w_idx)
         3'd1: begin w_a = W_A[1]; w_bc = W_BC[1]; w_d = W_D[1]; end
         3'd2: begin w_a = W_A[2]; w_bc = W_BC[2]; w_d = W_D[2]; end
         3'd3: begin w_a = W_A[3]; w_bc = W_BC[3]; w_d = W_D[3]; end
         default: ;
      endcase
   end

   // P1 payload, valid/finish pipeline and axial delay line; bubbles may be overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         fin_q <= '0;
         rad_q <= '0;
         ax_q  <= '0;
         dg_q  <= '0;
      end else if (advance) begin
         v_q     <= {v_q[2:0], data_valid_i};
         fin_q   <= {fin_q[2:0], finish_i};
         rad_q   <= radius_i;
         ax_q[0] <= {S_270_i, S_180_i, S_90_i, S_0_i};
         ax_q[1] <= ax_q[0];
         ax_q[2] <= ax_q[1];
         ax_q[3] <= ax_q[2];
         dg_q    <= {S_315_i, S_225_i, S_135_i, S_45_i};
      end
   end

   // Sticky configuration error, set by any accepted beat with an unsupported radius.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
      end else if (data_valid_i && advance && radius_illegal(radius_i, R_MAX)) begin
         cfg_err_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_diag
      interp_bilinear4 #(
         .DW (DW)
      ) u_diag (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (advance),
         .corners_i (dg_q[g]),
         .w_a_i     (w_a),
         .w_bc_i    (w_bc),
         .w_d_i     (w_d),
         .y_o       (diag_y[g])
      );
   end

   assign S1_o = {ax_q[3][0], {FRAC{1'b0}}};
   assign S2_o = diag_y[0];
   assign S3_o = {ax_q[3][1], {FRAC{1'b0}}};
   assign S4_o = diag_y[1];
   assign S5_o = {ax_q[3][2], {FRAC{1'b0}}};
   assign S6_o = diag_y[2];
   assign S7_o = {ax_q[3][3], {FRAC{1'b0}}};
   assign S8_o = diag_y[3];

   assign data_valid_o = v_q[3];
   assign finish_o     = v_q[3] && fin_q[3];
   assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_interpolation_ring.sv
// Scoreboard bench for interpolation_ring: directed beats, back-pressure stream, reset.
module tb_interpolation_ring;

   localparam int DW = 8;

   typedef struct packed {
      logic [7:0][23:0] s;
      logic             fin;
      logic [31:0]      acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_valid_i = 1'b0;
   logic        ready_o;
   logic        finish_i = 1'b0;
   logic [2:0]  radius_i = 3'd1;
   logic [7:0]  ax0 = '0, ax1 = '0, ax2 = '0, ax3 = '0;
   logic [31:0] dg0 = '0, dg1 = '0, dg2 = '0, dg3 = '0;
   logic [23:0] s1, s2, s3, s4, s5, s6, s7, s8;
   logic        data_valid_o;
   logic        ready_i = 1'b1;
   logic        finish_o;
   logic        cfg_err_o;

   logic [7:0][23:0] got;
   assign got = {s8, s7, s6, s5, s4, s3, s2, s1};

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          chk_lat = 1'b0;
   bit          prev_stall = 1'b0;
   bit          last_acc = 1'b0;
   logic [7:0][23:0] prev_got;
   logic        prev_fin;

   always #5 clk = ~clk;

   interpolation_ring #(
      .DW    (DW),
      .R_MAX (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_valid_i (data_valid_i),
      .ready_o      (ready_o),
      .finish_i     (finish_i),
      .radius_i     (radius_i),
      .S_0_i        (ax0),
      .S_90_i       (ax1),
      .S_180_i      (ax2),
      .S_270_i      (ax3),
      .S_45_i       (dg0),
      .S_135_i      (dg1),
      .S_225_i      (dg2),
      .S_315_i      (dg3),
      .S1_o         (s1),
      .S2_o         (s2),
      .S3_o         (s3),
      .S4_o         (s4),
      .S5_o         (s5),
      .S6_o         (s6),
      .S7_o         (s7),
      .S8_o         (s8),
      .data_valid_o (data_valid_o),
      .ready_i      (ready_i),
      .finish_o     (finish_o),
      .cfg_err_o    (cfg_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference bilinear result; corners packed {D,C,B,A}, bad radius uses the r=4 row.
   function automatic logic [23:0] model(input logic [31:0] cn, input logic [2:0] r);
      longint unsigned a, b, c, d, wa, wbc, wd, sum;
      logic [2:0] ri;
      a = cn[7:0]; b = cn[15:8]; c = cn[23:16]; d = cn[31:24];
      ri = (r == 3'd0 || r > 3'd4) ? 3'd4 : r;
      case (ri)
         3'd1:    begin wa = 65536; wbc = 0;     wd = 0;     end
         3'd2:    begin wa = 22488; wbc = 15902; wd = 11244; end
         3'd3:    begin wa = 50599; wbc = 6986;  wd = 965;   end
         default: begin wa = 1929;  wbc = 9315;  wd = 44977; end
      endcase
      sum = a * wa + (b + c) * wbc + d * wd;
      return sum[23:0];
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e.s[0] = {ax0, 16'h0};
      e.s[1] = model(dg0, radius_i);
      e.s[2] = {ax1, 16'h0};
      e.s[3] = model(dg1, radius_i);
      e.s[4] = {ax2, 16'h0};
      e.s[5] = model(dg2, radius_i);
      e.s[6] = {ax3, 16'h0};
      e.s[7] = model(dg3, radius_i);
      e.fin  = finish_i;
      e.acc  = cyc;
      return e;
   endfunction

   // One clock: sample and check at the falling edge, then return just after the rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      last_acc = 1'b0;
      chk("ready_o_rule", {31'b0, ready_o}, {31'b0, !(data_valid_o && !ready_i)});
      if (prev_stall) begin
         chk("stall_valid_held", {31'b0, data_valid_o}, 32'd1);
         for (int k = 0; k < 8; k++) chk($sformatf("stall_S%0d_held", k + 1), got[k], prev_got[k]);
         chk("stall_finish_held", {31'b0, finish_o}, {31'b0, prev_fin});
      end
      if (!data_valid_o) chk("finish_without_valid", {31'b0, finish_o}, 32'd0);
      if (data_valid_o && ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            for (int k = 0; k < 8; k++) chk($sformatf("S%0d_o", k + 1), got[k], e.s[k]);
            chk("finish_o", {31'b0, finish_o}, {31'b0, e.fin});
            if (chk_lat) chk("latency", cyc - e.acc, 32'd4);
         end
      end
      if (data_valid_i && ready_o) begin
         sb.push_back(expect_now());
         last_acc = 1'b1;
      end
      prev_stall = data_valid_o && !ready_i;
      prev_got   = got;
      prev_fin   = finish_o;
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int n, input logic [2:0] r, input logic f);
      ax0 = 8'(n);      ax1 = 8'(n + 8);  ax2 = 8'(n + 16); ax3 = 8'(n + 24);
      dg0 = {8'(n + 3),  8'(n + 2),  8'(n + 1),  8'(n)};
      dg1 = {8'(n + 7),  8'(n + 6),  8'(n + 5),  8'(n + 4)};
      dg2 = {8'(n + 11), 8'(n + 10), 8'(n + 9),  8'(n + 8)};
      dg3 = {8'(n + 15), 8'(n + 14), 8'(n + 13), 8'(n + 12)};
      radius_i = r;
      finish_i = f;
   endtask

   task automatic set_flat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [2:0] r);
      ax0 = a; ax1 = a; ax2 = a; ax3 = a;
      dg0 = {d, c, b, a}; dg1 = dg0; dg2 = dg0; dg3 = dg0;
      radius_i = r;
      finish_i = 1'b0;
   endtask

   // Pin every diagonal expectation of the newest beat to a fixed value.
   task automatic pin_diag(input logic [23:0] v);
      int t;
      t = sb.size() - 1;
      if (t >= 0) begin
         sb[t].s[1] = v; sb[t].s[3] = v; sb[t].s[5] = v; sb[t].s[7] = v;
      end
   endtask

   task automatic drain(input int n);
      data_valid_i = 1'b0;
      finish_i = 1'b0;
      ready_i = 1'b1;
      repeat (n) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, data_valid_o}, 32'd0);
      chk("rst_finish", {31'b0, finish_o}, 32'd0);
      chk("rst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_S%0d", k + 1), got[k], 32'd0);
      rst_n = 1'b1;

      // Flat input, r=2: every tap is 100.0 exactly four cycles after acceptance
      chk_lat = 1'b1;
      set_flat(8'd100, 8'd100, 8'd100, 8'd100, 3'd2);
      data_valid_i = 1'b1;
      step();
      for (int t = 0; t < sb.size(); t++)
         for (int k = 0; k < 8; k++) sb[t].s[k] = 24'd6553600;
      drain(6);

      // Corner weights, back to back
      data_valid_i = 1'b1;
      set_flat(8'd255, 8'd0, 8'd0, 8'd0, 3'd2); step(); pin_diag(24'd5734440);
      set_flat(8'd0, 8'd0, 8'd0, 8'd255, 3'd4); step(); pin_diag(24'd11469135);
      set_flat(8'd37, 8'd90, 8'd91, 8'd200, 3'd1); step(); pin_diag(24'd2424832);
      set_flat(8'd9, 8'd250, 8'd3, 8'd77, 3'd3); step();
      drain(6);

      // Finish sideband on beat 7 of 10
      data_valid_i = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         set_beat(i * 5, 3'(1 + i % 4), i == 7);
         step();
      end
      drain(6);
      chk("finish_run_drained", sb.size(), 32'd0);

      // Streaming with pseudo-random back-pressure
      chk_lat = 1'b0;
      n = 0;
      for (int s = 0; s < 400 && n < 20; s++) begin
         ready_i = 1'($urandom % 2);
         set_beat(n * 7 + 3, 3'(1 + n % 4), 1'b0);
         data_valid_i = 1'b1;
         step();
         if (last_acc) n++;
      end
      chk("stream_accepted", n, 32'd20);
      drain(10);
      chk("stream_drained", sb.size(), 32'd0);

      // Illegal radius uses r=4 weights and latches cfg_err_o
      chk_lat = 1'b1;
      chk("cfg_err_before", {31'b0, cfg_err_o}, 32'd0);
      data_valid_i = 1'b1;
      set_flat(8'd12, 8'd34, 8'd56, 8'd78, 3'd0);
      step();
      pin_diag(24'd12 * 24'd1929 + 24'd90 * 24'd9315 + 24'd78 * 24'd44977);
      chk("cfg_err_set", {31'b0, cfg_err_o}, 32'd1);
      set_flat(8'd12, 8'd34, 8'd56, 8'd78, 3'd2);
      step();
      drain(6);
      chk("cfg_err_sticky", {31'b0, cfg_err_o}, 32'd1);

      // Reset with three beats in flight
      data_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_beat(40 + i, 3'd2, 1'b0);
         step();
      end
      data_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, data_valid_o}, 32'd0);
      chk("mid_rst_finish", {31'b0, finish_o}, 32'd0);
      chk("mid_rst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
      for (int k = 0; k < 8; k++) chk($sformatf("mid_rst_S%0d", k + 1), got[k], 32'd0);
      sb.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'b0, ready_o}, 32'd1);
      @(posedge clk);
      #1;
      drain(10);
      chk("no_stale_beat", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
